// File: rtl/pdsch_dmrs_sched.sv
// ---------------------------------------------------------------------------
// pdsch_dmrs_sched
//   Per-slot sequencer for the PDSCH DMRS generator. Takes one slot config
//   and, for every DMRS symbol in its mask (lowest symbol first), computes the
//   38.211 c_init and issues one pdschrx_dmrsgen_t word. After each issue it
//   waits for the generator's last output beat before scheduling the next
//   symbol.
//
//   Optional feature macro: PDSCH_DMRS_SCHED_WDOG_EN
//     defined   : per-symbol watchdog. A symbol that sees no tlast within
//                 WDOG_CYCLES WAIT cycles pulses wdog_err and ends the slot.
//     undefined : no watchdog, wdog_err tied 0, WAIT blocks indefinitely.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   s_cfg_*         AXIS config in: {ns, nid, nscid, sym_mask[13:0],
//                   offset, length_dmrs}, MSB first
//   m_param_*       AXIS param out to the generator (pdschrx_dmrsgen_t)
//   mon_*           taps of the generator's output handshake / tlast
//   busy            high from config accept until slot_done
//   sym_idx         symbol currently scheduled
//   slot_done       1-cycle pulse at the end of a slot
//   wdog_err        1-cycle pulse on symbol timeout
//
// Timing (cycle 0 = handshake / tlast cycle)
//   m_param_tvalid rises in cycle 4 after a cfg handshake or a non-final tlast.
//   slot_done/busy fall/s_cfg_tready rise in cycle 2 after the final tlast
//   (or after the cfg handshake when the mask is empty).
// ---------------------------------------------------------------------------

package pdschrx_pkg;
    // Generator parameter word. Only cinit, offset and length_dmrs are
    // driven by this sequencer; the remaining fields are left at 0.
    typedef struct packed {
        logic [1:0]  dmrs_type;
        logic [3:0]  port_sel;
        logic [30:0] cinit;
        logic [15:0] offset;
        logic [15:0] length_dmrs;
    } pdschrx_dmrsgen_t;
endpackage

module pdsch_dmrs_sched #(
    parameter int NS_W        = 8,
    parameter int NID_W       = 16,
    parameter int LEN_W       = 16,
    parameter int WDOG_CYCLES = 65536
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NS_W+NID_W+1+14+2*LEN_W-1:0]  s_cfg_tdata,
    input  logic                                s_cfg_tvalid,
    output logic                                s_cfg_tready,
    output logic [$bits(pdschrx_pkg::pdschrx_dmrsgen_t)-1:0] m_param_tdata,
    output logic                                m_param_tvalid,
    input  logic                                m_param_tready,
    input  logic                                mon_tvalid,
    input  logic                                mon_tready,
    input  logic                                mon_tlast,
    output logic                                busy,
    output logic [3:0]                          sym_idx,
    output logic                                slot_done,
    output logic                                wdog_err
);

    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE, PICK, CALC1, CALC2, ISSUE, WAIT, DONE
    } state_t;

    state_t state;

    // config fields as presented on the bus
    logic [NS_W-1:0]  c_ns;
    logic [NID_W-1:0] c_nid;
    logic             c_nscid;
    logic [13:0]      c_mask;
    logic [LEN_W-1:0] c_off, c_len;

    assign {c_ns, c_nid, c_nscid, c_mask, c_off, c_len} = s_cfg_tdata;

    // latched slot config
    logic [NS_W-1:0]  ns_r;
    logic [NID_W-1:0] nid_r;
    logic             nscid_r;
    logic [13:0]      mask_rem;
    logic [LEN_W-1:0] off_r, len_r;

    // c_init pipeline
    logic [11:0]      a;
    logic [NID_W:0]   b;
    logic [13:0]      p;
    logic [30:0]      cinit;

    logic [3:0]       low_idx;
    logic             tlast_beat;

    assign tlast_beat = mon_tvalid & mon_tready & mon_tlast;

    // lowest set bit of the remaining mask
    always_comb begin
        low_idx = 4'd0;
        for (int i = 13; i >= 0; i--)
            if (mask_rem[i]) low_idx = 4'(i);
    end

    // Only the low 14 bits of a*b survive the <<17 under mod 2^31, so p is
    // the truncated product and the 31-bit sum wraps naturally.
    assign cinit = {p, 17'b0} + 31'({nid_r, 1'b0}) + 31'(nscid_r);

    pdschrx_pkg::pdschrx_dmrsgen_t prm;

    always_comb begin
        prm             = '0;
        prm.cinit       = cinit;
        prm.offset      = 16'(off_r);
        prm.length_dmrs = 16'(len_r);
    end

    assign m_param_tdata = prm;

`ifdef PDSCH_DMRS_SCHED_WDOG_EN
    logic [31:0] wcnt;
    logic        wdog_r;
    assign wdog_err = wdog_r;
`else
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            s_cfg_tready   <= 1'b1;
            m_param_tvalid <= 1'b0;
            busy           <= 1'b0;
            sym_idx        <= '0;
            slot_done      <= 1'b0;
            ns_r           <= '0;
            nid_r          <= '0;
            nscid_r        <= 1'b0;
            mask_rem       <= '0;
            off_r          <= '0;
            len_r          <= '0;
            a              <= '0;
            b              <= '0;
            p              <= '0;
`ifdef PDSCH_DMRS_SCHED_WDOG_EN
            wcnt           <= '0;
            wdog_r         <= 1'b0;
`endif
        end else begin
            slot_done <= 1'b0;
`ifdef PDSCH_DMRS_SCHED_WDOG_EN
            wdog_r    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (s_cfg_tvalid && s_cfg_tready) begin
                        ns_r         <= c_ns;
                        nid_r        <= c_nid;
                        nscid_r      <= c_nscid;
                        mask_rem     <= c_mask;
                        off_r        <= c_off;
                        len_r        <= c_len;
                        busy         <= 1'b1;
                        s_cfg_tready <= 1'b0;
                        state        <= (c_mask == 14'd0) ? DONE : PICK;
                    end
                end
                PICK: begin
                    sym_idx  <= low_idx;
                    // clear lowest set bit
                    mask_rem <= mask_rem & (mask_rem - 14'd1);
                    state    <= CALC1;
                end
                CALC1: begin
                    a     <= 12'(14 * ns_r) + 12'(sym_idx) + 12'd1;
                    b     <= {nid_r, 1'b1};
                    state <= CALC2;
                end
                CALC2: begin
                    p              <= 14'(a * b);
                    m_param_tvalid <= 1'b1;
                    state          <= ISSUE;
                end
                ISSUE: begin
                    if (m_param_tready) begin
                        m_param_tvalid <= 1'b0;
`ifdef PDSCH_DMRS_SCHED_WDOG_EN
                        wcnt           <= '0;
`endif
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (tlast_beat) begin
                        state <= (mask_rem == 14'd0) ? DONE : PICK;
                    end
`ifdef PDSCH_DMRS_SCHED_WDOG_EN
                    else if (wcnt == 32'(WDOG_CYCLES - 1)) begin
                        wdog_r   <= 1'b1;
                        mask_rem <= '0;
                        state    <= DONE;
                    end else begin
                        wcnt <= wcnt + 32'd1;
                    end
`endif
                end
                DONE: begin
                    slot_done    <= 1'b1;
                    busy         <= 1'b0;
                    s_cfg_tready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
